// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle coverage collector.
package toggle_cover_pkg;

  // Width of the index field carried through the event FIFO; the top
  // resizes it to its IDX_W output.
  localparam int unsigned EVT_IDX_W = 64;

  // Transition direction of a cover point.
  typedef enum logic {
    RISE = 1'b0,
    FALL = 1'b1
  } dir_e;

  // One coverage event as queued towards the consumer.
  typedef struct packed {
    logic [EVT_IDX_W-1:0] index;
    dir_e                 dir;
  } cover_evt_t;

  // Local point number of a (bit, direction) pair: rise and fall interleaved.
  function automatic int unsigned point(input int unsigned i, input dir_e dir);
    return (2 * i) + ((dir == FALL) ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/toggle_cover_fifo.sv
// Small synchronous FIFO for coverage events. Push is accepted while full
// when a pop happens on the same edge; flush empties it synchronously.
module toggle_cover_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [7:0]
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over any same-edge push or pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are meaningful, so resetting the data would only cost flops.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/toggle_cover_collector.sv
// Toggle coverage collector: detects per-bit rise/fall transitions, keeps a
// sticky coverage bitmap and reports each newly covered point once as a
// global cover index through a valid/ready event stream.
module toggle_cover_collector
  import toggle_cover_pkg::*;
#(
  parameter int unsigned     WIDTH       = 6,
  parameter longint unsigned COVER_INDEX = 0,
  parameter longint unsigned COVER_TOTAL = 38253,
  parameter int unsigned     FIFO_DEPTH  = 4,
  parameter int unsigned     IDX_W       = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               valid,
  input  logic                           enable,
  input  logic                           clear,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [IDX_W-1:0]               evt_index,
  output logic                           evt_dir,
  output logic [2*WIDTH-1:0]             covered,
  output logic [$clog2(2*WIDTH+1)-1:0]   hit_count,
  output logic                           all_covered
);

  localparam int unsigned NPTS = 2 * WIDTH;
  localparam int unsigned PW   = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam int unsigned CW   = $clog2(NPTS + 1);

  // COVER_TOTAL is informational; it only guards against an instance whose
  // points would fall outside the design-wide index range.
  if ((COVER_TOTAL != 0) && (COVER_INDEX + NPTS > COVER_TOTAL)) begin : g_range_error
    $error("toggle_cover_collector: cover points exceed COVER_TOTAL");
  end

  logic [WIDTH-1:0] prev_q;
  logic             primed_q;
  logic [NPTS-1:0]  covered_q;
  logic [NPTS-1:0]  pending_q;
  logic [NPTS-1:0]  covered_d;
  logic [NPTS-1:0]  pending_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [NPTS-1:0]  points;
  logic [NPTS-1:0]  new_pts;
  logic             detect_en;
  logic             scan_hit;
  logic [PW-1:0]    scan_sel;
  logic             evt_pop;
  logic             do_push;
  cover_evt_t       push_evt;
  cover_evt_t       head_evt;
  logic             fifo_full;
  logic             fifo_empty;

  function automatic logic [CW-1:0] count_ones(input logic [NPTS-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < NPTS; k++) cnt = cnt + CW'(v[k]);
    return cnt;
  endfunction

  // Edge detection, interleaving into point bits and first-hit filtering.
  // NOTE: every signal written here gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rise   = valid & ~prev_q;
    fall   = ~valid & prev_q;
    points = '0;
    for (int i = 0; i < WIDTH; i++) begin
      points[point(i, RISE)] = rise[i];
      points[point(i, FALL)] = fall[i];
    end
    detect_en = enable & primed_q & ~clear;
    new_pts   = detect_en ? (points & ~covered_q) : '0;
  end

  // Scanner: pick the lowest-numbered pending point (downward loop, last wins).
  always_comb begin
    scan_hit = 1'b0;
    scan_sel = '0;
    for (int k = NPTS - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        scan_hit = 1'b1;
        scan_sel = PW'(k);
      end
    end
  end

  assign evt_pop        = evt_valid & evt_ready;
  assign do_push        = scan_hit & ~clear & (~fifo_full | evt_pop);
  assign push_evt.index = EVT_IDX_W'(COVER_INDEX) + EVT_IDX_W'(scan_sel);
  assign push_evt.dir   = dir_e'(scan_sel[0]);

  // Next coverage and pending bitmaps; clear discards same-edge hits.
  always_comb begin
    pending_d = pending_q;
    if (do_push) pending_d[scan_sel] = 1'b0;
    pending_d = pending_d | new_pts;
    covered_d = covered_q | new_pts;
    if (clear) begin
      pending_d = '0;
      covered_d = '0;
    end
  end

  // Coverage state and registered summary counters.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q      <= '0;
      primed_q    <= 1'b0;
      covered_q   <= '0;
      pending_q   <= '0;
      hit_count   <= '0;
      all_covered <= 1'b0;
    end else begin
      prev_q      <= valid;
      primed_q    <= 1'b1;
      covered_q   <= covered_d;
      pending_q   <= pending_d;
      hit_count   <= count_ones(covered_d);
      all_covered <= &covered_d;
    end
  end

  toggle_cover_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cover_evt_t)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (clear),
    .push  (do_push),
    .din   (push_evt),
    .pop   (evt_pop),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head payload is forced to zero while empty so unwritten storage never shows.
  assign evt_valid = ~fifo_empty;
  assign evt_index = fifo_empty ? '0 : IDX_W'(head_evt.index);
  assign evt_dir   = fifo_empty ? 1'b0 : head_evt.dir;
  assign covered   = covered_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Self-checking bench for toggle_cover_collector (WIDTH=6, COVER_INDEX=100).
module tb_toggle_cover_collector;

  localparam int unsigned W    = 6;
  localparam int unsigned BASE = 100;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  valid = '0;
  logic          enable = 1'b1;
  logic          clear = 1'b0;
  logic          evt_valid;
  logic          evt_ready = 1'b1;
  logic [63:0]   evt_index;
  logic          evt_dir;
  logic [2*W-1:0] covered;
  logic [3:0]    hit_count;
  logic          all_covered;

  toggle_cover_collector #(
    .WIDTH       (W),
    .COVER_INDEX (BASE),
    .FIFO_DEPTH  (4),
    .IDX_W       (64)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .valid       (valid),
    .enable      (enable),
    .clear       (clear),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_index   (evt_index),
    .evt_dir     (evt_dir),
    .covered     (covered),
    .hit_count   (hit_count),
    .all_covered (all_covered)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint unsigned index;
    logic            dir;
  } exp_t;

  typedef struct {
    logic [W-1:0]   valid;
    logic           en;
    logic           clr;
    logic [2*W-1:0] cov;
    logic [3:0]     hits;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  logic [W-1:0]   m_prev;
  logic           m_primed;
  logic [2*W-1:0] m_cov;

  // Stall-stability tracking in the monitor
  logic        stalled = 1'b0;
  logic [63:0] held_idx;
  logic        held_dir;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Apply inputs now, take one rising edge, update model and expected events.
  task automatic step(input logic [W-1:0] v, input logic clr);
    logic [W-1:0]   r, f;
    logic [2*W-1:0] pts, nw;
    valid = v;
    clear = clr;
    @(posedge clock);
    r = v & ~m_prev;
    f = ~v & m_prev;
    for (int i = 0; i < W; i++) begin
      pts[2*i]   = r[i];
      pts[2*i+1] = f[i];
    end
    nw = (m_primed && enable && !clr) ? (pts & ~m_cov) : '0;
    for (int k = 0; k < 2*W; k++) begin
      if (nw[k]) exp_q.push_back('{index: BASE + k, dir: k[0]});
    end
    m_cov = clr ? '0 : (m_cov | nw);
    if (clr) exp_q.delete();
    m_prev   = v;
    m_primed = 1'b1;
    #1;
  endtask

  task automatic apply_reset(input logic [W-1:0] v);
    reset     = 1'b0;
    valid     = v;
    clear     = 1'b0;
    enable    = 1'b1;
    evt_ready = 1'b1;
    exp_q.delete();
    m_prev   = '0;
    m_primed = 1'b0;
    m_cov    = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_index", evt_index, 0);
    check("rst_evt_dir", evt_dir, 0);
    check("rst_covered", covered, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_all_covered", all_covered, 0);
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      step(valid, 1'b0);
    end
    step(valid, 1'b0);
    step(valid, 1'b0);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle_valid"}, evt_valid, 0);
  endtask

  // Monitor: compare handshaken events against the scoreboard and check
  // that a stalled head stays stable.
  always @(negedge clock) begin
    if (reset === 1'b1 && evt_valid === 1'b1) begin
      if (evt_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", evt_index, 0 - 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("evt_index", evt_index, e.index);
          check("evt_dir", evt_dir, e.dir);
        end
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_index", evt_index, held_idx);
          check("stall_dir", evt_dir, held_dir);
        end
        stalled  = 1'b1;
        held_idx = evt_index;
        held_dir = evt_dir;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{valid: 6'h00, en: 1'b1, clr: 1'b0, cov: 12'h000, hits: 4'd0};
    vecs[1] = '{valid: 6'h02, en: 1'b1, clr: 1'b0, cov: 12'h004, hits: 4'd1};
    vecs[2] = '{valid: 6'h02, en: 1'b1, clr: 1'b0, cov: 12'h004, hits: 4'd1};
    vecs[3] = '{valid: 6'h02, en: 1'b1, clr: 1'b0, cov: 12'h004, hits: 4'd1};
    vecs[4] = '{valid: 6'h02, en: 1'b1, clr: 1'b0, cov: 12'h004, hits: 4'd1};
    vecs[5] = '{valid: 6'h00, en: 1'b1, clr: 1'b1, cov: 12'h000, hits: 4'd0};
    vecs[6] = '{valid: 6'h02, en: 1'b0, clr: 1'b0, cov: 12'h000, hits: 4'd0};
    vecs[7] = '{valid: 6'h00, en: 1'b1, clr: 1'b0, cov: 12'h008, hits: 4'd1};

    // 1: single rise, latency and bitmap position
    apply_reset(6'h00);
    step(6'h00, 1'b0);
    step(6'h00, 1'b0);
    step(6'h04, 1'b0);
    check("t1_covered", covered, 12'h010);
    check("t1_hit_count", hit_count, 1);
    check("t1_not_yet_valid", evt_valid, 0);
    step(6'h04, 1'b0);
    check("t1_valid_after_push", evt_valid, 1);
    check("t1_head_index", evt_index, 104);
    drain("t1");

    // 2: six simultaneous rises under backpressure
    apply_reset(6'h00);
    step(6'h00, 1'b0);
    step(6'h00, 1'b0);
    evt_ready = 1'b0;
    step(6'h3F, 1'b0);
    check("t2_covered", covered, 12'h555);
    check("t2_hit_count", hit_count, 6);
    for (int i = 0; i < 6; i++) step(6'h3F, 1'b0);
    check("t2_stalled_valid", evt_valid, 1);
    check("t2_stalled_head", evt_index, 100);
    evt_ready = 1'b1;
    drain("t2");
    check("t2_final_hits", hit_count, 6);

    // 3: repeated toggles of one bit report each point once
    apply_reset(6'h00);
    step(6'h00, 1'b0);
    step(6'h01, 1'b0);
    step(6'h00, 1'b0);
    step(6'h01, 1'b0);
    drain("t3");
    check("t3_covered", covered, 12'h003);
    check("t3_hit_count", hit_count, 2);

    // 4: values present through reset and priming edge never count
    apply_reset(6'h3F);
    step(6'h3F, 1'b0);
    for (int i = 0; i < 3; i++) step(6'h3F, 1'b0);
    check("t4_covered_primed", covered, 12'h000);
    check("t4_no_event", evt_valid, 0);
    step(6'h00, 1'b0);
    drain("t4");
    check("t4_covered", covered, 12'hAAA);
    check("t4_hit_count", hit_count, 6);

    // 5: clear against a same-edge fall, table driven
    apply_reset(6'h00);
    for (int i = 0; i < 8; i++) begin
      enable = vecs[i].en;
      step(vecs[i].valid, vecs[i].clr);
      check($sformatf("t5_covered_%0d", i), covered, vecs[i].cov);
      check($sformatf("t5_hits_%0d", i), hit_count, vecs[i].hits);
    end
    enable = 1'b1;
    drain("t5");

    // 6: full coverage, then asynchronous reset mid-stream
    apply_reset(6'h00);
    step(6'h00, 1'b0);
    step(6'h3F, 1'b0);
    check("t6_half_hits", hit_count, 6);
    check("t6_not_all", all_covered, 0);
    step(6'h00, 1'b0);
    check("t6_all_covered", all_covered, 1);
    check("t6_hit_count", hit_count, 12);
    check("t6_pre_reset_valid", evt_valid, 1);
    #1;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("t6_async_valid", evt_valid, 0);
    check("t6_async_covered", covered, 0);
    check("t6_async_all", all_covered, 0);
    apply_reset(6'h00);
    for (int i = 0; i < 8; i++) step(6'h00, 1'b0);
    check("t6_quiet_valid", evt_valid, 0);
    check("t6_quiet_covered", covered, 0);
    check("t6_quiet_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
